// File: rtl/point_mem_ctrl_if.sv
// Stream and single-port RAM bundle for the point-memory controller.
// The slave side is the controller; the master side is its environment.
interface point_mem_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 50
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;

    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_d;
    logic [DATA_W-1:0] ram_q;

    modport slave (
        input  in_valid, in_data, in_last, out_ready, ram_q,
        output in_ready, out_valid, out_data, out_last,
        output ram_ce, ram_we, ram_addr, ram_d
    );

    modport master (
        output in_valid, in_data, in_last, out_ready, ram_q,
        input  in_ready, out_valid, out_data, out_last,
        input  ram_ce, ram_we, ram_addr, ram_d
    );
endinterface

// File: rtl/point_mem_ctrl.sv
// Loads a point stream into an external single-port RAM and replays it on demand
// through a 2-entry output buffer that tolerates arbitrary downstream backpressure.
module point_mem_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 50,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic              read_start,
    point_mem_ctrl_if.slave   bus,
    output logic [ADDR_W:0]   num_points,
    output logic              busy,
    output logic              full,
    output logic              done
);
    localparam logic [ADDR_W:0] DEPTH_V = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, READ} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W:0]   num_q, num_d;       // doubles as the write pointer during LOAD
    logic [ADDR_W:0]   rd_addr_q, rd_addr_d;
    logic              inflight_q, inflight_d;
    logic              infl_last_q, infl_last_d;
    logic              done_q, done_d;
    logic [1:0]        cnt_q;
    logic              head_q;
    logic [DATA_W-1:0] buf_data_q [2];
    logic              buf_last_q [2];

    logic              pop;
    logic              tail;
    logic [2:0]        occ;

    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_data  = buf_data_q[head_q];
    assign bus.out_last  = bus.out_valid & buf_last_q[head_q];
    assign pop           = bus.out_valid & bus.out_ready;
    assign tail          = head_q ^ cnt_q[0];
    // Slots that will be occupied after this cycle, counting reads still in the RAM pipe.
    assign occ           = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};

    assign num_points = num_q;
    assign busy       = (state_q != IDLE);
    assign full       = (num_q == DEPTH_V);
    assign done       = done_q;

    always_comb begin
        state_d      = state_q;
        num_d        = num_q;
        rd_addr_d    = rd_addr_q;
        inflight_d   = 1'b0;
        infl_last_d  = 1'b0;
        done_d       = 1'b0;
        bus.in_ready = 1'b0;
        bus.ram_ce   = 1'b0;
        bus.ram_we   = 1'b0;
        bus.ram_addr = '0;
        bus.ram_d    = '0;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    state_d = LOAD;
                    num_d   = '0;
                end else if (read_start) begin
                    if (num_q == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // Issue address 0 right away to reach the 2-cycle first-word latency.
                        state_d     = READ;
                        bus.ram_ce  = 1'b1;
                        rd_addr_d   = (ADDR_W+1)'(1);
                        inflight_d  = 1'b1;
                        infl_last_d = (num_q == (ADDR_W+1)'(1));
                    end
                end
            end
            LOAD: begin
                bus.in_ready = (num_q < DEPTH_V);
                if (bus.in_valid && bus.in_ready) begin
                    bus.ram_ce   = 1'b1;
                    bus.ram_we   = 1'b1;
                    bus.ram_addr = num_q[ADDR_W-1:0];
                    bus.ram_d    = bus.in_data;
                    num_d        = num_q + 1'b1;
                    if (bus.in_last || (num_q == DEPTH_V - 1'b1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            READ: begin
                if ((rd_addr_q < num_q) && (occ < 3'd2)) begin
                    bus.ram_ce   = 1'b1;
                    bus.ram_addr = rd_addr_q[ADDR_W-1:0];
                    rd_addr_d    = rd_addr_q + 1'b1;
                    inflight_d   = 1'b1;
                    infl_last_d  = (rd_addr_q == num_q - 1'b1);
                end
                if (pop && bus.out_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            num_q       <= '0;
            rd_addr_q   <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= 2'd0;
            head_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            rd_addr_q   <= rd_addr_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
            cnt_q       <= cnt_q + {1'b0, inflight_q} - {1'b0, pop};
            if (pop) begin
                head_q <= ~head_q;
            end
        end
    end

    // Word read in the previous cycle lands in the next free buffer slot.
    always_ff @(posedge clk) begin
        if (inflight_q) begin
            buf_data_q[tail] <= bus.ram_q;
            buf_last_q[tail] <= infl_last_q;
        end
    end
endmodule
